// File: rtl/move_controller_if.sv
// Mouse/board-side signal bundle for the move controller.
interface move_controller_if;
    logic        click;
    logic [5:0]  click_pos;
    logic [3:0]  query_code;
    logic [63:0] possible_moves;
    logic        white_win;
    logic        black_win;
    logic [5:0]  query_pos;
    logic [5:0]  figure_position;
    logic        pick_piece;
    logic        place_piece;
    logic        turn;
    logic        selected;
    logic [5:0]  sel_pos;
    logic        illegal;
    logic        game_over;
    logic [9:0]  move_count;
    logic        timeout;

    // Environment side: mouse decoder, board and move generator.
    modport master (
        output click, click_pos, query_code, possible_moves, white_win, black_win,
        input  query_pos, figure_position, pick_piece, place_piece, turn, selected,
        input  sel_pos, illegal, game_over, move_count, timeout
    );

    // Controller side.
    modport slave (
        input  click, click_pos, query_code, possible_moves, white_win, black_win,
        output query_pos, figure_position, pick_piece, place_piece, turn, selected,
        output sel_pos, illegal, game_over, move_count, timeout
    );
endinterface

// File: rtl/move_controller.sv
// Turn/move sequencer: turns square clicks into pick/place pulses, enforces
// colour alternation and legal destinations, and stops at game over.
// Optional per-turn time limit enabled by defining TURN_TIMER_EN.
module move_controller #(
    parameter int unsigned SETTLE_CYC = 2
`ifdef TURN_TIMER_EN
    ,
    // Nominal limit of 6e9 cycles does not fit the 32-bit counter; clamp to its maximum.
    parameter logic [31:0] TURN_CYC = 32'hFFFF_FFFF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    move_controller_if.slave bus
);

    localparam int unsigned POS_W = 6;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned SET_W = 4;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HELD   = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [POS_W-1:0]   r_pos, w_pos_nxt;
    logic [POS_W-1:0]   r_query_pos, w_query_pos_nxt;
    logic [POS_W-1:0]   r_fig_pos, w_fig_pos_nxt;
    logic [POS_W-1:0]   r_sel_pos, w_sel_pos_nxt;
    logic               r_pick, w_pick_nxt;
    logic               r_place, w_place_nxt;
    logic               r_turn, w_turn_nxt;
    logic               r_selected, w_selected_nxt;
    logic               r_illegal, w_illegal_nxt;
    logic               r_game_over, w_game_over_nxt;
    logic [CNT_W-1:0]   r_move_count, w_move_count_nxt;
    logic [SET_W-1:0]   r_settle_cnt, w_settle_cnt_nxt;

    logic               w_win;
    logic               w_expire;
    logic               w_own;
    logic               w_stop;
    logic               w_hit_sel;
    logic               w_legal_dst;

    assign w_win       = bus.white_win | bus.black_win;
    assign w_stop      = (r_state != ST_OVER) && (w_win || w_expire);
    assign w_hit_sel   = (bus.click_pos == r_sel_pos);
    assign w_legal_dst = bus.possible_moves[bus.click_pos];

    // Side-to-move ownership: white codes 1..6, black codes 7..12.
    assign w_own = r_turn ? ((bus.query_code >= 4'd7) && (bus.query_code <= 4'd12))
                          : ((bus.query_code >= 4'd1) && (bus.query_code <= 4'd6));

`ifdef TURN_TIMER_EN
    logic [31:0] r_turn_cnt;
    logic        r_timeout;

    assign w_expire = (r_state != ST_OVER) && (r_turn_cnt == (TURN_CYC - 32'd1));

    // Per-turn cycle counter, restarted whenever the side to move changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_turn_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_turn_nxt != r_turn) begin
                r_turn_cnt <= '0;
            end else if (r_state != ST_OVER) begin
                r_turn_cnt <= r_turn_cnt + 32'd1;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_expire    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a win or timeout overrides any click.
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = ST_OVER;
        end else begin
            case (r_state)
                ST_IDLE:   if (bus.click) w_state_nxt = ST_LOOKUP;
                ST_LOOKUP: w_state_nxt = ST_CHECK;
                ST_CHECK:  w_state_nxt = w_own ? ST_SETTLE : ST_IDLE;
                ST_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_HELD;
                ST_HELD:   if (bus.click && (w_hit_sel || w_legal_dst)) w_state_nxt = ST_IDLE;
                ST_OVER:   w_state_nxt = ST_OVER;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output logic: next values of all registered outputs.
    always_comb begin
        w_pick_nxt       = 1'b0;
        w_place_nxt      = 1'b0;
        w_illegal_nxt    = 1'b0;
        w_pos_nxt        = r_pos;
        w_query_pos_nxt  = r_query_pos;
        w_fig_pos_nxt    = r_fig_pos;
        w_sel_pos_nxt    = r_sel_pos;
        w_turn_nxt       = r_turn;
        w_selected_nxt   = r_selected;
        w_game_over_nxt  = r_game_over;
        w_move_count_nxt = r_move_count;
        w_settle_cnt_nxt = r_settle_cnt;
        if (w_stop) begin
            w_game_over_nxt = 1'b1;
            // Timeout with a piece in hand puts it back; a win leaves it as is.
            if (!w_win && r_selected) begin
                w_place_nxt    = 1'b1;
                w_fig_pos_nxt  = r_sel_pos;
                w_selected_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.click) begin
                        w_query_pos_nxt = bus.click_pos;
                        w_pos_nxt       = bus.click_pos;
                    end
                end
                ST_CHECK: begin
                    if (w_own) begin
                        w_pick_nxt       = 1'b1;
                        w_fig_pos_nxt    = r_pos;
                        w_sel_pos_nxt    = r_pos;
                        w_selected_nxt   = 1'b1;
                        w_settle_cnt_nxt = '0;
                    end else begin
                        w_illegal_nxt = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    w_settle_cnt_nxt = r_settle_cnt + SET_W'(1);
                end
                ST_HELD: begin
                    if (bus.click) begin
                        if (w_hit_sel) begin
                            w_place_nxt    = 1'b1;
                            w_fig_pos_nxt  = r_sel_pos;
                            w_selected_nxt = 1'b0;
                        end else if (w_legal_dst) begin
                            w_place_nxt    = 1'b1;
                            w_fig_pos_nxt  = bus.click_pos;
                            w_selected_nxt = 1'b0;
                            w_turn_nxt     = ~r_turn;
                            if (r_move_count != CNT_MAX) begin
                                w_move_count_nxt = r_move_count + CNT_W'(1);
                            end
                        end else begin
                            w_illegal_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos        <= '0;
            r_query_pos  <= '0;
            r_fig_pos    <= '0;
            r_sel_pos    <= '0;
            r_pick       <= 1'b0;
            r_place      <= 1'b0;
            r_turn       <= 1'b0;
            r_selected   <= 1'b0;
            r_illegal    <= 1'b0;
            r_game_over  <= 1'b0;
            r_move_count <= '0;
            r_settle_cnt <= '0;
        end else begin
            r_pos        <= w_pos_nxt;
            r_query_pos  <= w_query_pos_nxt;
            r_fig_pos    <= w_fig_pos_nxt;
            r_sel_pos    <= w_sel_pos_nxt;
            r_pick       <= w_pick_nxt;
            r_place      <= w_place_nxt;
            r_turn       <= w_turn_nxt;
            r_selected   <= w_selected_nxt;
            r_illegal    <= w_illegal_nxt;
            r_game_over  <= w_game_over_nxt;
            r_move_count <= w_move_count_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
        end
    end

    assign bus.query_pos       = r_query_pos;
    assign bus.figure_position = r_fig_pos;
    assign bus.pick_piece      = r_pick;
    assign bus.place_piece     = r_place;
    assign bus.turn            = r_turn;
    assign bus.selected        = r_selected;
    assign bus.sel_pos         = r_sel_pos;
    assign bus.illegal         = r_illegal;
    assign bus.game_over       = r_game_over;
    assign bus.move_count      = r_move_count;

endmodule
